// File: rtl/ioblock_cfg_pkg.sv
// ============================================================================
// Module      : ioblock_cfg_pkg
// Description : Shared types and constants for the ioblock26 config sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ioblock_cfg_pkg;

    localparam int CFG_BITS_PER_IO = 3;

    // TSMUX encodings; TS_DRIVE covers both 2'b10 and 2'b11
    localparam logic [1:0] TS_HIZ   = 2'b00;
    localparam logic [1:0] TS_CTRL  = 2'b01;
    localparam logic [1:0] TS_DRIVE = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        LATCH   = 2'd2,
        DONE_ST = 2'd3
    } cfg_state_t;

    function automatic logic ts_drives(input logic [1:0] ts);
        return ts[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ioblock_cfg_shadow.sv
// ============================================================================
// Module      : ioblock_cfg_shadow
// Description : NUM_IO x 3 shadow register file, one write port, bit-serial read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ioblock_cfg_shadow
    import ioblock_cfg_pkg::*;
#(
    parameter int NUM_IO = 8,
    parameter int AW     = 3,
    parameter int IW     = 5
) (
    input  logic                       IOCLK,
    input  logic                       IORSTN,
    input  logic                       i_wr_en,
    input  logic [AW-1:0]              i_wr_addr,
    input  logic [CFG_BITS_PER_IO-1:0] i_wr_data,
    input  logic [IW-1:0]              i_rd_idx,
    output logic                       o_rd_bit
);

    // Flat image: cell k occupies bits [3k+2:3k], so the highest cell sits at the MSBs
    logic [NUM_IO*CFG_BITS_PER_IO-1:0] w_flat;

    generate
        for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_cell
            logic [CFG_BITS_PER_IO-1:0] r_word;

            always_ff @(posedge IOCLK or negedge IORSTN) begin
                if (!IORSTN) begin
                    r_word <= '0;
                end else if (i_wr_en && (i_wr_addr == AW'(gi))) begin
                    r_word <= i_wr_data;
                end
            end

            assign w_flat[gi*CFG_BITS_PER_IO +: CFG_BITS_PER_IO] = r_word;
        end
    endgenerate

    assign o_rd_bit = w_flat[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/ioblock_cfg_ctrl.sv
// ============================================================================
// Module      : ioblock_cfg_ctrl
// Description : Shadow image + serial loader for a chain of ioblock26 I/O cells.
//               Optional readback of the old chain image: CFG_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ioblock_cfg_ctrl
    import ioblock_cfg_pkg::*;
#(
    parameter int NUM_IO = 8,
    parameter int AW     = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
    input  logic                       IOCLK,
    input  logic                       IORSTN,
    input  logic                       WR_VALID,
    output logic                       WR_READY,
    input  logic [AW-1:0]              WR_ADDR,
    input  logic [CFG_BITS_PER_IO-1:0] WR_DATA,
    input  logic                       START,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       ADDR_ERR,
    output logic                       CFG_DOUT,
    output logic                       CFG_SHIFT,
    output logic                       CFG_LATCH,
`ifdef CFG_READBACK_EN
    input  logic [AW-1:0]              RB_ADDR,
    output logic [CFG_BITS_PER_IO-1:0] RB_DATA,
`endif
    input  logic                       CFG_DIN
);

    localparam int NB = NUM_IO * CFG_BITS_PER_IO;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] c_last = CW'(NB - 1);

    cfg_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_wr_ready, r_busy, r_done, r_addr_err;
    logic          r_dout, r_shift, r_latch;

    logic          w_wr_fire, w_addr_ok, w_shadow_we;
    logic [CW-1:0] w_cnt_nxt, w_rd_idx;
    logic          w_rd_bit, w_bit;

    assign w_wr_fire   = WR_VALID && r_wr_ready;
    assign w_addr_ok   = (32'(WR_ADDR) < 32'(NUM_IO));
    assign w_shadow_we = w_wr_fire && w_addr_ok;

    assign w_cnt_nxt = (r_state == IDLE) ? '0 : (r_cnt + 1'b1);
    assign w_rd_idx  = c_last - w_cnt_nxt;

    // The first bit leaves at the same edge a write may land; forward it
    assign w_bit = (w_shadow_we && (WR_ADDR == AW'(NUM_IO - 1)))
                 ? WR_DATA[CFG_BITS_PER_IO-1] : w_rd_bit;

    ioblock_cfg_shadow #(
        .NUM_IO (NUM_IO),
        .AW     (AW),
        .IW     (CW)
    ) u_shadow (
        .IOCLK     (IOCLK),
        .IORSTN    (IORSTN),
        .i_wr_en   (w_shadow_we),
        .i_wr_addr (WR_ADDR),
        .i_wr_data (WR_DATA),
        .i_rd_idx  (w_rd_idx),
        .o_rd_bit  (w_rd_bit)
    );

    always_ff @(posedge IOCLK or negedge IORSTN) begin
        if (!IORSTN) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
            r_dout     <= 1'b0;
            r_shift    <= 1'b0;
            r_latch    <= 1'b0;
        end else begin
            r_addr_err <= w_wr_fire && !w_addr_ok;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_state    <= SHIFT;
                        r_cnt      <= '0;
                        r_wr_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_shift    <= 1'b1;
                        r_dout     <= w_bit;
                    end
                end
                SHIFT: begin
                    if (r_cnt == c_last) begin
                        r_state <= LATCH;
                        r_shift <= 1'b0;
                        r_dout  <= 1'b0;
                        r_latch <= 1'b1;
                    end else begin
                        r_cnt  <= w_cnt_nxt;
                        r_dout <= w_bit;
                    end
                end
                LATCH: begin
                    r_state <= DONE_ST;
                    r_latch <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                DONE_ST: begin
                    r_state    <= IDLE;
                    r_done     <= 1'b0;
                    r_wr_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign WR_READY  = r_wr_ready;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign ADDR_ERR  = r_addr_err;
    assign CFG_DOUT  = r_dout;
    assign CFG_SHIFT = r_shift;
    assign CFG_LATCH = r_latch;

`ifdef CFG_READBACK_EN
    // Old chain image leaves the tail highest-cell-first, so shifting left
    // rebuilds the same flat layout as the shadow
    logic [NB-1:0] r_rb;

    always_ff @(posedge IOCLK or negedge IORSTN) begin
        if (!IORSTN) begin
            r_rb <= '0;
        end else if (r_state == SHIFT) begin
            r_rb <= {r_rb[NB-2:0], CFG_DIN};
        end
    end

    always_comb begin
        RB_DATA = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            if (RB_ADDR == AW'(i)) begin
                RB_DATA = r_rb[i*CFG_BITS_PER_IO +: CFG_BITS_PER_IO];
            end
        end
    end
`else
    logic w_unused_din;
    assign w_unused_din = CFG_DIN;
`endif

endmodule

`default_nettype wire
